// File: rtl/key_freq_encoder.sv
// key_freq_encoder: PS/2 keyboard front end that turns piano-layout key presses
// into a note id plus a one-cycle "new note" strobe.
//
// Receives 11-bit device-to-host PS/2 frames (start, 8 data LSB first, odd
// parity, stop), validates them and decodes set-2 make/break codes. 25 keys
// map to note ids 0..24.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   ps2_clk    in   raw keyboard clock (asynchronous, idle high)
//   ps2_data   in   raw keyboard data (asynchronous, idle high)
//   freq_id    out  [4:0] note id, 0 lowest .. 24 highest; holds last value
//   new_f      out  one-cycle strobe: freq_id is valid and new
//   key_held   out  high while the key that set freq_id is down
//   frame_err  out  one-cycle strobe on parity/stop error or mid-frame timeout
module key_freq_encoder #(
    parameter int unsigned TIMEOUT = 65000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] freq_id,
    output logic       new_f,
    output logic       key_held,
    output logic       frame_err
);

    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StShift, StCheck} rx_state_e;

    rx_state_e         rx_state;
    logic              clk_meta, sync_clk, sync_clk_d;
    logic              data_meta, sync_data;
    logic [3:0]        bit_cnt;
    logic [9:0]        shift_reg;
    logic [TimerW-1:0] timer;
    logic              clk_fall;
    logic              frame_good;
    logic              byte_valid;
    logic [7:0]        rx_byte;
    logic              ext_flag, brk_flag;
    logic              key_hit;
    logic [4:0]        key_id;

    // Two-flop synchronisers; reset to the idle-high level so reset never
    // manufactures a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta   <= 1'b1;
            sync_clk   <= 1'b1;
            sync_clk_d <= 1'b1;
            data_meta  <= 1'b1;
            sync_data  <= 1'b1;
        end else begin
            clk_meta   <= ps2_clk;
            sync_clk   <= clk_meta;
            sync_clk_d <= sync_clk;
            data_meta  <= ps2_data;
            sync_data  <= data_meta;
        end
    end

    assign clk_fall = sync_clk_d & ~sync_clk;

    // After the stop bit: shift_reg[7:0] = data, [8] = parity, [9] = stop.
    assign rx_byte    = shift_reg[7:0];
    assign frame_good = (^shift_reg[8:0]) & shift_reg[9];
    assign byte_valid = (rx_state == StCheck) && frame_good;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state  <= StIdle;
            bit_cnt   <= 4'd0;
            shift_reg <= 10'd0;
            timer     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (rx_state)
                StIdle: begin
                    timer <= '0;
                    if (clk_fall && !sync_data) begin
                        rx_state <= StShift;
                        bit_cnt  <= 4'd0;
                    end
                end
                StShift: begin
                    if (clk_fall) begin
                        timer     <= '0;
                        shift_reg <= {sync_data, shift_reg[9:1]};
                        if (bit_cnt == 4'd9) begin
                            rx_state <= StCheck;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (timer == TimerW'(TIMEOUT - 1)) begin
                        // Keyboard stalled mid-frame: drop the partial byte.
                        rx_state  <= StIdle;
                        timer     <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StCheck: begin
                    rx_state <= StIdle;
                    if (!frame_good) begin
                        frame_err <= 1'b1;
                    end
                end
                default: rx_state <= StIdle;
            endcase
        end
    end

    // Set-2 scancode to note id.
    always_comb begin
        key_hit = 1'b1;
        key_id  = 5'd0;
        case (rx_byte)
            8'h1A: key_id = 5'd0;
            8'h1B: key_id = 5'd1;
            8'h22: key_id = 5'd2;
            8'h23: key_id = 5'd3;
            8'h21: key_id = 5'd4;
            8'h2A: key_id = 5'd5;
            8'h34: key_id = 5'd6;
            8'h32: key_id = 5'd7;
            8'h33: key_id = 5'd8;
            8'h31: key_id = 5'd9;
            8'h3B: key_id = 5'd10;
            8'h3A: key_id = 5'd11;
            8'h41: key_id = 5'd12;
            8'h15: key_id = 5'd13;
            8'h1E: key_id = 5'd14;
            8'h1D: key_id = 5'd15;
            8'h26: key_id = 5'd16;
            8'h24: key_id = 5'd17;
            8'h2D: key_id = 5'd18;
            8'h2E: key_id = 5'd19;
            8'h2C: key_id = 5'd20;
            8'h36: key_id = 5'd21;
            8'h35: key_id = 5'd22;
            8'h3D: key_id = 5'd23;
            8'h3C: key_id = 5'd24;
            default: key_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            freq_id  <= 5'd0;
            new_f    <= 1'b0;
            key_held <= 1'b0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else begin
            new_f <= 1'b0;
            if (byte_valid) begin
                case (rx_byte)
                    8'hE0: ext_flag <= 1'b1;
                    8'hF0: brk_flag <= 1'b1;
                    default: begin
                        // Prefix flags apply to exactly one following byte.
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                        if (!ext_flag && key_hit) begin
                            if (!brk_flag) begin
                                // Same key while still held is typematic repeat.
                                if (!(key_held && key_id == freq_id)) begin
                                    freq_id  <= key_id;
                                    new_f    <= 1'b1;
                                    key_held <= 1'b1;
                                end
                            end else if (key_held && key_id == freq_id) begin
                                key_held <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_freq_encoder.sv
// tb_key_freq_encoder: drives PS/2 frames into key_freq_encoder and compares
// strobes, note id and held flag against a scancode-level reference model.
module tb_key_freq_encoder;

    localparam int unsigned TMO  = 300;
    localparam int          HALF = 4;  // system cycles per PS/2 half period

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [4:0] freq_id;
    logic       new_f, key_held, frame_err;

    int checks = 0;
    int errors = 0;

    key_freq_encoder #(.TIMEOUT(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .freq_id   (freq_id),
        .new_f     (new_f),
        .key_held  (key_held),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    // Monitor: timestamps ps2_clk falls and output strobes in system cycles.
    int   cyc = 0;
    int   last_fall = 0;
    logic prev_clk = 1'b1;
    int   nf_cyc[$];
    int   fe_cnt = 0;
    int   coinc = 0;

    always @(negedge clock) begin
        #2;
        cyc++;
        if (prev_clk && !ps2_clk) last_fall = cyc;
        prev_clk = ps2_clk;
        if (new_f) nf_cyc.push_back(cyc);
        if (frame_err) fe_cnt++;
        if (new_f && frame_err) coinc++;
    end

    // Reference model state.
    logic [7:0] codes [25] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
                               8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41, 8'h15, 8'h1E, 8'h1D,
                               8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D,
                               8'h3C};
    int m_fid  = 0;
    bit m_held = 0;
    bit m_ext  = 0;
    bit m_brk  = 0;

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 25; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b, output bit nf);
        int k;
        nf = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = lookup(b);
            if (!m_ext && k >= 0) begin
                if (!m_brk) begin
                    if (!(m_held && k == m_fid)) begin
                        m_fid = k; m_held = 1; nf = 1;
                    end
                end else if (m_held && k == m_fid) m_held = 0;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit pflip,
                                             input bit stop);
        return {stop, (~^b) ^ pflip, b, 1'b0};
    endfunction

    task automatic clear_mon();
        @(negedge clock);
        nf_cyc.delete();
        fe_cnt = 0;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit pflip, input bit stop,
                            input string tag);
        bit exp_nf;
        int exp_fe;
        clear_mon();
        if (!pflip && stop) begin
            model_byte(b, exp_nf);
            exp_fe = 0;
        end else begin
            exp_nf = 0;
            exp_fe = 1;
        end
        send_bits(mk_frame(b, pflip, stop), 11);
        repeat (6) @(negedge clock);
        #3;
        check({tag, ".new_f_count"}, nf_cyc.size(), exp_nf);
        if (exp_nf && nf_cyc.size() > 0)
            check({tag, ".latency"}, nf_cyc[0] - last_fall, 4);
        check({tag, ".freq_id"}, freq_id, m_fid);
        check({tag, ".key_held"}, key_held, m_held);
        check({tag, ".frame_err_count"}, fe_cnt, exp_fe);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        bit bad_p, bad_s;

        repeat (3) @(negedge clock);
        #3;
        check("reset.freq_id", freq_id, 0);
        check("reset.new_f", new_f, 0);
        check("reset.key_held", key_held, 0);
        check("reset.frame_err", frame_err, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        do_frame(8'h1A, 0, 1, "make_1a");
        do_frame(8'h3C, 0, 1, "make_3c");
        for (int i = 0; i < 3; i++) do_frame(8'h3C, 0, 1, "typematic_3c");
        do_frame(8'hF0, 0, 1, "brk_prefix");
        do_frame(8'h3C, 0, 1, "break_3c");
        do_frame(8'h1A, 0, 1, "press_1a");
        do_frame(8'hF0, 0, 1, "brk_prefix2");
        do_frame(8'h22, 0, 1, "break_other");
        do_frame(8'hE0, 0, 1, "ext_prefix");
        do_frame(8'h75, 0, 1, "ext_75");
        do_frame(8'h75, 0, 1, "plain_75");
        do_frame(8'h1A, 1, 1, "parity_err");
        do_frame(8'h1A, 0, 0, "stop_err");

        // Stall mid-frame until the receiver gives up.
        clear_mon();
        send_bits(mk_frame(8'h22, 0, 1), 5);
        repeat (TMO + 10) @(negedge clock);
        #3;
        check("timeout.frame_err_count", fe_cnt, 1);
        check("timeout.new_f_count", nf_cyc.size(), 0);
        do_frame(8'h22, 0, 1, "after_timeout");

        // Reset in the middle of a frame aborts it silently.
        clear_mon();
        send_bits(mk_frame(8'h41, 0, 1), 5);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_fid = 0; m_held = 0; m_ext = 0; m_brk = 0;
        repeat (TMO + 10) @(negedge clock);
        #3;
        check("midreset.freq_id", freq_id, 0);
        check("midreset.key_held", key_held, 0);
        check("midreset.new_f_count", nf_cyc.size(), 0);
        check("midreset.frame_err_count", fe_cnt, 0);
        do_frame(8'h41, 0, 1, "after_reset_41");

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            bad_p = 0;
            bad_s = 1;
            case (r)
                0, 1, 2, 3, 4: b = codes[$urandom_range(0, 24)];
                5: b = 8'hF0;
                6: b = 8'hE0;
                7: b = codes[m_fid];
                8: b = 8'($urandom);
                default: begin
                    b = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) bad_p = 1;
                    else bad_s = 0;
                end
            endcase
            do_frame(b, bad_p, bad_s, "random");
        end

        check("strobe_coincidence", coinc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
